// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier; otherwise opcode 111 flags an error.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_v,
    output logic         flag_err
);

    localparam int unsigned SW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        HOLD     = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd2
    } state_t;
`endif

    state_t       state_q, state_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] result_hi_q, result_hi_d;
    logic         c_q, c_d;
    logic         z_q, z_d;
    logic         n_q, n_d;
    logic         v_q, v_d;
    logic         err_q, err_d;

    logic         in_ready_c;
    logic         accept_c;
    logic         start_mul_c;

    logic [W:0]    add_c;
    logic [W:0]    sub_c;
    logic [W:0]    shl_ext_c;
    logic [SW-1:0] sh_amt_c;
    logic          amt_ge_w_c;
    logic          amt_eq_w_c;
    logic [W-1:0]  alu_res_c;
    logic          alu_c_c;
    logic          alu_v_c;
    logic          alu_z_c;
    logic          alu_err_c;

    // Single-cycle datapath; the whole of b is compared so amounts >= W saturate to zero
    always_comb begin
        add_c      = {1'b0, a} + {1'b0, b};
        sub_c      = {1'b0, a} - {1'b0, b};
        sh_amt_c   = b[SW-1:0];
        amt_ge_w_c = (b >= W'(W));
        amt_eq_w_c = (b == W'(W));
        shl_ext_c  = {1'b0, a} << sh_amt_c;
        alu_res_c  = '0;
        alu_c_c    = 1'b0;
        alu_v_c    = 1'b0;
        alu_err_c  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_c = add_c[W-1:0];
                alu_c_c   = add_c[W];
                alu_v_c   = (a[W-1] == b[W-1]) && (add_c[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_res_c = sub_c[W-1:0];
                alu_c_c   = sub_c[W];
                alu_v_c   = (a[W-1] != b[W-1]) && (sub_c[W-1] != a[W-1]);
            end
            OP_AND: alu_res_c = a & b;
            OP_OR:  alu_res_c = a | b;
            OP_XOR: alu_res_c = a ^ b;
            OP_SHL: begin
                if (amt_ge_w_c) begin
                    alu_c_c = amt_eq_w_c & a[0];
                end else begin
                    alu_res_c = shl_ext_c[W-1:0];
                    alu_c_c   = shl_ext_c[W];
                end
            end
            OP_SHR: begin
                if (!amt_ge_w_c) begin
                    alu_res_c = a >> sh_amt_c;
                end
            end
            OP_MUL: begin
`ifndef ALU_MUL_EN
                alu_err_c = 1'b1;
`endif
            end
            default: ;
        endcase
        alu_z_c = (alu_res_c == '0);
    end

`ifdef ALU_MUL_EN
    logic [2*W-1:0] prod_q, prod_d;
    logic [2*W-1:0] prod_step_c;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [W:0]     part_c;

    // One shift-add step: low half holds the remaining multiplier bits, high half the partial sum
    always_comb begin
        part_c      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step_c = {part_c, prod_q[W-1:1]};
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        err_d       = err_q;
`ifdef ALU_MUL_EN
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
`endif
        in_ready_c  = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        accept_c    = in_valid && in_ready_c;
`ifdef ALU_MUL_EN
        start_mul_c = accept_c && (op == OP_MUL);
`else
        start_mul_c = 1'b0;
`endif

        case (state_q)
            IDLE, HOLD: begin
                if ((state_q == HOLD) && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept_c && !start_mul_c) begin
                    result_d    = alu_res_c;
                    result_hi_d = '0;
                    c_d         = alu_c_c;
                    z_d         = alu_z_c;
                    n_d         = alu_res_c[W-1];
                    v_d         = alu_v_c;
                    err_d       = alu_err_c;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
`ifdef ALU_MUL_EN
                if (start_mul_c) begin
                    mcand_d = a;
                    prod_d  = {{W{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = MUL_BUSY;
                end
`endif
            end
`ifdef ALU_MUL_EN
            MUL_BUSY: begin
                prod_d = prod_step_c;
                cnt_d  = cnt_q + SW'(1);
                if (cnt_q == SW'(W - 1)) begin
                    result_d    = prod_step_c[W-1:0];
                    result_hi_d = prod_step_c[2*W-1:W];
                    c_d         = 1'b0;
                    z_d         = (prod_step_c == '0);
                    n_d         = prod_step_c[W-1];
                    v_d         = |prod_step_c[2*W-1:W];
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            err_q       <= err_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;
    assign flag_err  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq at W=8, plus handshake, MUL and reset sequences.
module tb_alu_seq;

    localparam int unsigned W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // flg packs {c, z, n, v, err}
    typedef struct {
        int           id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   flg;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_c;
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;
    logic         flag_err;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[$];
    vec_t mon_e;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input int id, input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [W-1:0] r, input logic [W-1:0] h, input logic [4:0] f);
        vec_t v;
        v.id  = id;
        v.op  = o;
        v.a   = ia;
        v.b   = ib;
        v.res = r;
        v.hi  = h;
        v.flg = f;
        return v;
    endfunction

    function automatic void add(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [W-1:0] r, input logic [W-1:0] h, input logic [4:0] f);
        tbl.push_back(mk(tbl.size(), o, ia, ib, r, h, f));
    endfunction

    // Consumer side: every transfer pops the oldest expected record
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got result %0h with empty scoreboard, required no output", result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", mon_e.id, 64'({result_hi, result}), 64'({mon_e.hi, mon_e.res}));
                chk("flags", mon_e.id, 64'({flag_c, flag_z, flag_n, flag_v, flag_err}), 64'(mon_e.flg));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            sb.push_back(v);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d]: in_ready stayed 0, required 1", v.id);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 0, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;

        add(OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000);
        add(OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00010);
        add(OP_SUB, 8'h01, 8'h02, 8'hFF, 8'h00, 5'b10100);
        add(OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000);
        add(OP_OR,  8'h0F, 8'h80, 8'h8F, 8'h00, 5'b00100);
        add(OP_XOR, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b01000);
        add(OP_XOR, 8'hA5, 8'h0F, 8'hAA, 8'h00, 5'b00100);
        add(OP_SHL, 8'h81, 8'h01, 8'h02, 8'h00, 5'b10000);
        add(OP_SHL, 8'h81, 8'h08, 8'h00, 8'h00, 5'b11000);
        add(OP_SHR, 8'h81, 8'h09, 8'h00, 8'h00, 5'b01000);
        add(OP_SHL, 8'h81, 8'h00, 8'h81, 8'h00, 5'b00100);
        add(OP_SHR, 8'h80, 8'h07, 8'h01, 8'h00, 5'b00000);
        add(OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b00110);
        add(OP_SHL, 8'h03, 8'h07, 8'h80, 8'h00, 5'b10100);
        add(OP_SUB, 8'h05, 8'h05, 8'h00, 8'h00, 5'b01000);
        add(OP_SHR, 8'hF0, 8'h04, 8'h0F, 8'h00, 5'b00000);
        add(OP_ADD, 8'h80, 8'h80, 8'h00, 8'h00, 5'b11010);
`ifdef ALU_MUL_EN
        add(OP_MUL, 8'h0F, 8'h11, 8'hFF, 8'h00, 5'b00100);
        add(OP_MUL, 8'h00, 8'h37, 8'h00, 8'h00, 5'b01000);
        add(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00010);
`else
        add(OP_MUL, 8'h0F, 8'h11, 8'h00, 8'h00, 5'b01001);
`endif

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 0, 64'(in_ready), 64'(0));
        chk("rst_out_valid", 0, 64'(out_valid), 64'(0));
        chk("rst_result", 0, 64'({result_hi, result}), 64'(0));
        chk("rst_flags", 0, 64'({flag_c, flag_z, flag_n, flag_v, flag_err}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 0, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Streaming table with the consumer always ready
        out_ready = 1'b1;
        foreach (tbl[i]) send(tbl[i]);
        drain();

        // Backpressure then back-to-back transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = OP_ADD;
        a  = 8'h10;
        b  = 8'h20;
        @(negedge clk);
        chk("bp_accept", 100, 64'(in_ready), 64'(1));
        if (in_ready) sb.push_back(mk(100, OP_ADD, 8'h10, 8'h20, 8'h30, 8'h00, 5'b00000));
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", k, 64'(out_valid), 64'(1));
            chk("bp_hold", k, 64'(result), 64'(8'h30));
            chk("bp_in_ready", k, 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_accept", 101, 64'(in_ready), 64'(1));
        if (in_ready) sb.push_back(mk(101, OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 5'b00000));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 101, 64'(out_valid), 64'(1));
        chk("b2b_result", 101, 64'(result), 64'(8'h02));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_drop", 101, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Multiplier latency
        in_valid = 1'b1;
        op = OP_MUL;
        a  = 8'hC8;
        b  = 8'hC8;
        @(negedge clk);
        chk("mul_accept", 102, 64'(in_ready), 64'(1));
`ifdef ALU_MUL_EN
        if (in_ready) sb.push_back(mk(102, OP_MUL, 8'hC8, 8'hC8, 8'h40, 8'h9C, 5'b00010));
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mul_busy_ready", k, 64'(in_ready), 64'(0));
            chk("mul_busy_valid", k, 64'(out_valid), 64'(0));
        end
        @(negedge clk);
        chk("mul_done_valid", 102, 64'(out_valid), 64'(1));
`else
        if (in_ready) sb.push_back(mk(102, OP_MUL, 8'hC8, 8'hC8, 8'h00, 8'h00, 5'b01001));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mul_err_valid", 102, 64'(out_valid), 64'(1));
        chk("mul_err_flag", 102, 64'(flag_err), 64'(1));
`endif
        @(posedge clk);
        #1;
        drain();

        // Reset in the middle of an operation; the aborted op must never complete
`ifdef ALU_MUL_EN
        in_valid = 1'b1;
        op = OP_MUL;
`else
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = OP_ADD;
`endif
        a = 8'h55;
        b = 8'h03;
        @(negedge clk);
        chk("abort_accept", 103, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 103, 64'(in_ready), 64'(0));
        chk("mid_rst_out_valid", 103, 64'(out_valid), 64'(0));
        chk("mid_rst_result", 103, 64'({result_hi, result}), 64'(0));
        chk("mid_rst_flags", 103, 64'({flag_c, flag_z, flag_n, flag_v, flag_err}), 64'(0));
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 104, 64'(in_ready), 64'(1));
        chk("post_rst_valid", 104, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        send(mk(104, OP_ADD, 8'h03, 8'h04, 8'h07, 8'h00, 5'b00000));
        @(negedge clk);
        chk("post_rst_lat", 104, 64'(out_valid), 64'(1));
        chk("post_rst_result", 104, 64'(result), 64'(8'h07));
        @(posedge clk);
        #1;
        drain();
        repeat (12) @(posedge clk);
        #1;
        chk("idle_valid", 105, 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. Accepts one operation per valid/ready handshake and returns a registered result with status flags through an output valid/ready handshake. Adds XOR, logical shifts and a multi-cycle shift-add multiplier. Sits between the TinyTapeout pin wrapper and user logic.

Parameters:
W, 8, operand/result width in bits; legal range 4..32
SW, $clog2(W), shift-amount width; derived, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept an operation this cycle
op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
a  in  W  operand A
b  in  W  operand B; for shifts, shift amount is b[SW-1:0]
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer takes the result this cycle
result  out  W  result, low W bits
result_hi  out  W  high W bits of MUL product; 0 for all other ops
flag_c  out  1  carry / borrow / shift-out
flag_z  out  1  zero
flag_n  out  1  negative, result[W-1]
flag_v  out  1  signed overflow, or MUL high half non-zero
flag_err  out  1  illegal op (MUL opcode when multiplier is compiled out)

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid, result, result_hi, all flags = 0; in_ready = 0 while rst_n is low. in_ready = 1 in the first cycle after release.
- FSM states: IDLE, MUL_BUSY, HOLD.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). Accept = in_valid & in_ready.
- Non-MUL op accepted: result and flags registered on the accept edge. out_valid = 1 on the next cycle. Latency 1. State goes to HOLD.
- MUL accepted: a and b are latched; state goes to MUL_BUSY. One shift-add step per cycle for W cycles; in_ready = 0 throughout. After the W-th step, the result registers load and out_valid = 1. Latency W+1 edges from accept to out_valid.
- HOLD: result and flags stay stable while out_ready = 0.
  - out_ready = 1 with no new accept: out_valid drops next cycle; state returns to IDLE.
  - out_ready = 1 with a simultaneous accept: back-to-back transfer, out_valid stays 1 with the new result.
- Arithmetic, all unsigned modulo 2^W:
  - ADD: flag_c = carry out; flag_v = signed overflow.
  - SUB: a-b; flag_c = borrow (a<b unsigned); flag_v = signed overflow.
  - AND, OR, XOR: flag_c = flag_v = 0.
  - SHL, SHR: logical, zero fill. Amount >= W gives result 0. SHL flag_c = last bit shifted out for 1<=amt<=W, else 0. SHR flag_c = 0. flag_v = 0.
  - MUL: 2W-bit product split into {result_hi, result}. flag_v = (result_hi != 0). flag_c = 0. flag_z = (full product == 0).
- flag_n = result[W-1] for every op. flag_z = (result == 0) for every op except MUL.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- in_valid while in_ready = 0 is ignored. No sampling of op, a or b occurs.

Optional Feature:
ALU_MUL_EN
- Defined: MUL behaves as above, with multi-cycle MUL_BUSY.
- Undefined: MUL_BUSY and the multiplier datapath are absent. Opcode 111 completes with latency 1: result = 0, result_hi = 0, flag_z = 1, flag_err = 1, other flags 0.
- flag_err is 0 for every op when ALU_MUL_EN is defined.

Test Plan:
- W=8, ADD a=0xFF b=0x01 -> result 0x00, c=1, z=1, v=0, n=0; out_valid one cycle after accept.
- W=8, SUB a=0x80 b=0x01 -> 0x7F, v=1, c=0, n=0. Then SUB a=0x01 b=0x02 -> 0xFF, c=1, n=1.
- W=8, ALU_MUL_EN, MUL 0xC8*0xC8 -> result_hi 0x9C, result 0x40, v=1. in_ready low 8 cycles; out_valid 9 edges after accept. MUL 0x0F*0x11 -> hi 0x00, lo 0xFF, v=0.
- W=8, SHL a=0x81 b=0x01 -> 0x02, c=1. SHL b=0x08 -> 0x00, c=1. SHR a=0x81 b=0x09 -> 0x00, c=0.
- Backpressure: hold out_ready=0 for 5 cycles after ADD -> result stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 with in_valid=1 -> back-to-back accept, out_valid stays 1 with the new result.
- Reset: assert rst_n=0 three cycles into MUL -> all outputs 0 immediately. After release, in_ready=1 and a fresh ADD 0x03+0x04 -> 0x07. Without ALU_MUL_EN: MUL -> err=1, z=1, latency 1.
